// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the FIFO write port among NUM_REQ producers in bursts of up to MAX_BURST beats.
// Optional handshake/overflow checker driving err is built only when FIFO_WR_ARB_CHK_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          w_full,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, sel_lo, sel_hi, next_ptr;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            any_hi, valid_g, last_g, accept, done;
  assign valid_g  = req_valid[grant_id_q];
  assign last_g   = req_last[grant_id_q];
  assign accept   = state_q == GRANT && valid_g && !w_full;
  assign done     = last_g || beat_cnt_q == BW'(MAX_BURST - 1);
  assign next_ptr = grant_id_q == IW'(NUM_REQ - 1) ? '0 : grant_id_q + IW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    sel_lo     = '0;
    sel_hi     = '0;
    any_hi     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) sel_lo = IW'(i);
      if (req_valid[i] && IW'(i) >= rr_ptr_q) begin
        sel_hi = IW'(i);
        any_hi = 1'b1;
      end
    end
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (|req_valid) begin
        state_d    = GRANT;
        grant_id_d = any_hi ? sel_hi : sel_lo;
        beat_cnt_d = '0;
      end
    end else if (!valid_g || (accept && done)) begin
      state_d  = IDLE;
      rr_ptr_d = next_ptr;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + BW'(1);
    end
  end
  always_comb begin
    busy      = state_q == GRANT;
    req_ready = busy && !w_full ? NUM_REQ'(1) << grant_id_q : '0;
    w_inc     = accept;
    w_data    = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    grant_id  = grant_id_q;
  end
`ifdef FIFO_WR_ARB_CHK_EN
  logic [NUM_REQ-1:0]            pv_q, pr_q, pl_q;
  logic [NUM_REQ*DATA_WIDTH-1:0] pd_q;
  logic                          err_q, err_d, viol;
  // A stalled beat must keep valid, data and last unchanged until it is accepted.
  always_comb begin
    viol = w_inc && w_full;
    for (int i = 0; i < NUM_REQ; i++)
      viol = viol || (pv_q[i] && !pr_q[i] && (!req_valid[i] || req_last[i] != pl_q[i] ||
             req_data[i*DATA_WIDTH +: DATA_WIDTH] != pd_q[i*DATA_WIDTH +: DATA_WIDTH]));
    err_d = err_q || viol;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q  <= '0;
      pr_q  <= '0;
      pl_q  <= '0;
      pd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pv_q  <= req_valid;
      pr_q  <= req_ready;
      pl_q  <= req_last;
      pd_q  <= req_data;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule
